// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: IR layout, opcodes, FSM states,
// datapath select encodings and the per-state output decode.
package control_sequencer_pkg;

    localparam int IR_OP_MSB  = 15;
    localparam int IR_OP_LSB  = 12;
    localparam int IR_DST_MSB = 11;
    localparam int IR_DST_LSB = 9;
    localparam int IR_SRC_MSB = 8;
    localparam int IR_SRC_LSB = 6;
    localparam int IR_IMM_MSB = 5;
    localparam int IR_IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        BUS_MEM = 2'd0,
        BUS_IMM = 2'd1,
        BUS_ALU = 2'd2,
        BUS_SRC = 2'd3
    } bus_sel_e;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       in_en;
        logic       out_en;
        logic [2:0] src_sel;
        logic [2:0] dst_sel;
        logic [1:0] bus_sel;
        logic       alu_op;
        logic       halted;
        logic       fault;
    } ctrl_t;

    function automatic logic [3:0] ir_op(input logic [15:0] ir);
        return ir[IR_OP_MSB:IR_OP_LSB];
    endfunction

    function automatic logic [2:0] ir_dst(input logic [15:0] ir);
        return ir[IR_DST_MSB:IR_DST_LSB];
    endfunction

    function automatic logic [2:0] ir_src(input logic [15:0] ir);
        return ir[IR_SRC_MSB:IR_SRC_LSB];
    endfunction

    // Where EXEC hands over to for a given opcode.
    function automatic state_e exec_next(input logic [3:0] op);
        state_e nxt;
        case (op)
            OP_NOP, OP_MOV, OP_LDI,
            OP_ADD, OP_SUB, OP_JMP: nxt = ST_FETCH;
            OP_LD, OP_ST:           nxt = ST_MEM;
            OP_HALT:                nxt = ST_HALT;
            default:                nxt = ST_FAULT;
        endcase
        return nxt;
    endfunction

    // Steady outputs for a state; evaluated for the state being entered so the
    // result can be registered alongside the state itself.
    function automatic ctrl_t ctrl_decode(input state_e st, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_req = 1'b1;
                c.out_en  = 1'b1;
            end
            ST_DECODE: begin
                c.src_sel = ir_src(ir);
                c.dst_sel = ir_dst(ir);
            end
            ST_EXEC: begin
                c.src_sel = ir_src(ir);
                c.dst_sel = ir_dst(ir);
                case (ir_op(ir))
                    OP_MOV: begin
                        c.in_en   = 1'b1;
                        c.bus_sel = BUS_SRC;
                    end
                    OP_LDI: begin
                        c.in_en   = 1'b1;
                        c.bus_sel = BUS_IMM;
                    end
                    OP_ADD: begin
                        c.in_en   = 1'b1;
                        c.bus_sel = BUS_ALU;
                        c.alu_op  = ALU_ADD;
                    end
                    OP_SUB: begin
                        c.in_en   = 1'b1;
                        c.bus_sel = BUS_ALU;
                        c.alu_op  = ALU_SUB;
                    end
                    OP_JMP: begin
                        c.dst_sel = 3'd0;
                        c.in_en   = 1'b1;
                        c.bus_sel = BUS_SRC;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                c.mem_req = 1'b1;
                c.mem_we  = (ir_op(ir) == OP_ST);
                c.out_en  = 1'b1;
                c.src_sel = ir_src(ir);
                c.dst_sel = ir_dst(ir);
                c.bus_sel = BUS_MEM;
            end
            ST_HALT:  c.halted = 1'b1;
            ST_FAULT: c.fault  = 1'b1;
            default:  c.fault  = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_timeout.sv
// Memory-request watchdog: counts consecutive unacknowledged request cycles and
// flags the cycle that would take the count up to MEM_TIMEOUT.
module seq_timeout #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (busy && !ack && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Asserting in the MEM_TIMEOUT-th waiting cycle lets the FSM drop mem_req
    // on the very next cycle.
    assign expired = busy && !ack && (count_reg == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetches 16-bit instructions, decodes them and
// steers a register file, ALU and memory port through FETCH/DECODE/EXEC/MEM.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  src_sel,
    output logic [2:0]  dst_sel,
    output logic        in_en,
    output logic        out_en,
    output logic        pc_inc,
    output logic [1:0]  bus_sel,
    output logic        alu_op,
    output logic [15:0] imm,
    output logic        halted,
    output logic        fault
);

    state_e      state_reg;
    logic [15:0] ir_reg;
    ctrl_t       ctrl_reg;
    logic        ack_q;
    logic        expired;
    logic        tmo_clr;

    // An acknowledge only counts while a request is actually outstanding.
    assign ack_q   = mem_ack && ctrl_reg.mem_req;
    // EXEC precedes every entry to FETCH/MEM except MEM->FETCH, which is an ack.
    assign tmo_clr = ack_q || (state_reg == ST_EXEC);

    seq_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .busy    (ctrl_reg.mem_req),
        .ack     (ack_q),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_FETCH;
            ir_reg    <= '0;
            ctrl_reg  <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (expired) begin
                        state_reg <= ST_FAULT;
                        ctrl_reg  <= ctrl_decode(ST_FAULT, ir_reg);
                    end else if (ack_q) begin
                        ir_reg    <= mem_rdata;
                        state_reg <= ST_DECODE;
                        ctrl_reg  <= ctrl_decode(ST_DECODE, mem_rdata);
                    end else begin
                        ctrl_reg  <= ctrl_decode(ST_FETCH, ir_reg);
                    end
                end
                ST_DECODE: begin
                    state_reg <= ST_EXEC;
                    ctrl_reg  <= ctrl_decode(ST_EXEC, ir_reg);
                end
                ST_EXEC: begin
                    state_reg <= exec_next(ir_op(ir_reg));
                    ctrl_reg  <= ctrl_decode(exec_next(ir_op(ir_reg)), ir_reg);
                end
                ST_MEM: begin
                    if (expired) begin
                        state_reg <= ST_FAULT;
                        ctrl_reg  <= ctrl_decode(ST_FAULT, ir_reg);
                    end else if (ack_q) begin
                        state_reg <= ST_FETCH;
                        ctrl_reg  <= ctrl_decode(ST_FETCH, ir_reg);
                    end
                end
                ST_HALT, ST_FAULT: ;
                default: begin
                    state_reg <= ST_FAULT;
                    ctrl_reg  <= ctrl_decode(ST_FAULT, ir_reg);
                end
            endcase
        end
    end

    // The ack-qualified strobes are the only outputs not taken straight from
    // registers; they depend on mem_ack but never on mem_rdata.
    assign pc_inc  = (state_reg == ST_FETCH) && ack_q;
    assign in_en   = ctrl_reg.in_en ||
                     ((state_reg == ST_MEM) && (ir_op(ir_reg) == OP_LD) && ack_q);

    assign mem_req = ctrl_reg.mem_req;
    assign mem_we  = ctrl_reg.mem_we;
    assign out_en  = ctrl_reg.out_en;
    assign src_sel = ctrl_reg.src_sel;
    assign dst_sel = ctrl_reg.dst_sel;
    assign bus_sel = ctrl_reg.bus_sel;
    assign alu_op  = ctrl_reg.alu_op;
    assign halted  = ctrl_reg.halted;
    assign fault   = ctrl_reg.fault;
    assign imm     = {10'd0, ir_reg[IR_IMM_MSB:IR_IMM_LSB]};

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a memory responder issues directed and
// random programs, a model queues the expected register-file/memory activity.
module tb_control_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, in_en, out_en, pc_inc, alu_op, halted, fault;
    logic [2:0]  src_sel, dst_sel;
    logic [1:0]  bus_sel;
    logic [15:0] imm;

    control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .src_sel(src_sel), .dst_sel(dst_sel),
        .in_en(in_en), .out_en(out_en), .pc_inc(pc_inc), .bus_sel(bus_sel),
        .alu_op(alu_op), .imm(imm), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_inc, in_en, mem_acc, mem_we, out_en;
        logic [2:0]  src, dst;
        logic [1:0]  bus;
        logic        alu;
        logic [15:0] imm;
        logic        c_src, c_dst, c_bus, c_alu, c_imm;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", name, txn_no, act, req);
        end
    endtask

    // Reference model: what the register file / memory port should see.
    task automatic push_fetch();
        rec_t e;
        e = '0;
        e.pc_inc = 1'b1; e.mem_acc = 1'b1; e.mem_we = 1'b0; e.out_en = 1'b1;
        e.c_src = 1'b1;  e.src = 3'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_effect(input logic [15:0] ins);
        rec_t e;
        logic [3:0] op;
        logic [2:0] d, s;
        op = ins[15:12]; d = ins[11:9]; s = ins[8:6];
        e = '0;
        case (op)
            4'h1: begin e.in_en = 1; e.c_dst = 1; e.dst = d; e.c_src = 1; e.src = s; e.c_bus = 1; e.bus = 2'd3; end
            4'h2: begin e.in_en = 1; e.c_dst = 1; e.dst = d; e.c_bus = 1; e.bus = 2'd1;
                        e.c_imm = 1; e.imm = {10'd0, ins[5:0]}; end
            4'h3: begin e.mem_acc = 1; e.mem_we = 0; e.out_en = 1; e.c_src = 1; e.src = s;
                        e.in_en = 1; e.c_bus = 1; e.bus = 2'd0; e.c_dst = 1; e.dst = d; end
            4'h4: begin e.mem_acc = 1; e.mem_we = 1; e.out_en = 1; e.c_src = 1; e.src = s;
                        e.c_dst = 1; e.dst = d; end
            4'h5, 4'h6: begin e.in_en = 1; e.c_dst = 1; e.dst = d; e.c_src = 1; e.src = s;
                        e.c_bus = 1; e.bus = 2'd2; e.c_alu = 1; e.alu = (op == 4'h6); end
            4'h7: begin e.in_en = 1; e.c_dst = 1; e.dst = 3'd0; e.c_src = 1; e.src = s; e.c_bus = 1; e.bus = 2'd3; end
            default: ;
        endcase
        if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7})
            exp_q.push_back(e);
    endtask

    task automatic compare(input rec_t e);
        check("pc_inc", {31'd0, pc_inc}, {31'd0, e.pc_inc});
        check("in_en", {31'd0, in_en}, {31'd0, e.in_en});
        check("mem_txn", {31'd0, mem_req && mem_ack}, {31'd0, e.mem_acc});
        if (e.mem_acc) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, e.mem_we});
            check("out_en", {31'd0, out_en}, {31'd0, e.out_en});
        end
        if (e.c_src) check("src_sel", {29'd0, src_sel}, {29'd0, e.src});
        if (e.c_dst) check("dst_sel", {29'd0, dst_sel}, {29'd0, e.dst});
        if (e.c_bus) check("bus_sel", {30'd0, bus_sel}, {30'd0, e.bus});
        if (e.c_alu) check("alu_op", {31'd0, alu_op}, {31'd0, e.alu});
        if (e.c_imm) check("imm", {16'd0, imm}, {16'd0, e.imm});
    endtask

    // Monitor: one scoreboard pop per cycle in which the DUT acts.
    initial begin : monitor
        logic prev_wr;
        rec_t e;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_wr = 1'b0;
            end else begin
                if (prev_wr) check("mem_req_after_write", {31'd0, mem_req}, 32'd1);
                if (in_en) check("pc_inc_with_pc_write", {31'd0, pc_inc && (dst_sel == 3'd0)}, 32'd0);
                prev_wr = in_en;
                if (pc_inc || in_en || (mem_req && mem_ack)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", {29'd0, pc_inc, in_en, mem_ack}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        compare(e);
                    end
                end
            end
        end
    end

    // Memory responder: random ack noise while idle, then hold the request for
    // 'waits' cycles checking its attributes, then acknowledge with 'data'.
    task automatic mem_txn(input string name, input logic [15:0] data, input int waits,
                           input logic we, input logic [2:0] src, input logic chk_dst,
                           input logic [2:0] dst);
        int guard;
        guard = 0;
        while (mem_req !== 1'b1) begin
            if (guard >= 50) begin
                check({name, "_req_wait"}, {31'd0, mem_req}, 32'd1);
                mem_ack = 1'b0;
                return;
            end
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i <= waits; i++) begin
            check({name, "_req_hold"}, {31'd0, mem_req}, 32'd1);
            check({name, "_we"}, {31'd0, mem_we}, {31'd0, we});
            check({name, "_out_en"}, {31'd0, out_en}, 32'd1);
            check({name, "_src"}, {29'd0, src_sel}, {29'd0, src});
            if (chk_dst) check({name, "_dst"}, {29'd0, dst_sel}, {29'd0, dst});
            if (i == waits) begin
                mem_ack = 1'b1; mem_rdata = data;
            end else begin
                mem_ack = 1'b0; mem_rdata = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input int fw, input int dw);
        txn_no++;
        push_fetch();
        push_effect(ins);
        mem_txn("fetch", ins, fw, 1'b0, 3'd0, 1'b0, 3'd0);
        if (ins[15:12] == 4'h3) mem_txn("ld", 16'($urandom), dw, 1'b0, ins[8:6], 1'b0, 3'd0);
        if (ins[15:12] == 4'h4) mem_txn("st", 16'($urandom), dw, 1'b1, ins[8:6], 1'b1, ins[11:9]);
        $display("txn %0d: ir=0x%04h fetch_wait=%0d data_wait=%0d", txn_no, ins, fw, dw);
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_in_en", {31'd0, in_en}, 32'd0);
        check("rst_out_en", {31'd0, out_en}, 32'd0);
        check("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
        check("rst_src_sel", {29'd0, src_sel}, 32'd0);
        check("rst_dst_sel", {29'd0, dst_sel}, 32'd0);
        check("rst_bus_sel", {30'd0, bus_sel}, 32'd0);
        check("rst_alu_op", {31'd0, alu_op}, 32'd0);
        check("rst_imm", {16'd0, imm}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mem_req_first_edge", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic check_sticky(input string name, input logic exp_halt, input logic exp_fault);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            check({name, "_mem_req"}, {31'd0, mem_req}, 32'd0);
            check({name, "_strobes"}, {29'd0, in_en, out_en, pc_inc}, 32'd0);
            check({name, "_halted"}, {31'd0, halted}, {31'd0, exp_halt});
            check({name, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    initial begin : stim
        logic [15:0] directed [5] = '{16'h2205, 16'h5450, 16'h3440, 16'h4440, 16'h7040};
        int          fwait    [5] = '{2, 0, 1, 0, 1};
        int          dwait    [5] = '{0, 0, 3, 2, 0};
        logic [15:0] ins;
        int          n;

        do_reset();
        for (int i = 0; i < 5; i++) issue(directed[i], fwait[i], dwait[i]);
        for (int i = 0; i < 60; i++) begin
            ins = {4'($urandom_range(0, 7)), 12'($urandom)};
            issue(ins, $urandom_range(0, 4), $urandom_range(0, 4));
        end
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 32'd0);

        issue(16'hF000, 1, 0);
        n = 0;
        while (!halted && n < 10) begin @(posedge clk); #1; n++; end
        check("halt_reached", {31'd0, halted}, 32'd1);
        check_sticky("halt", 1'b1, 1'b0);

        do_reset();
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!mem_req) break;
            n++;
        end
        txn_no++;
        $display("txn %0d: no ack, mem_req held %0d cycles", txn_no, n);
        check("timeout_req_cycles", n, MEM_TIMEOUT);
        check("timeout_fault", {31'd0, fault}, 32'd1);
        check_sticky("timeout", 1'b0, 1'b1);

        do_reset();
        issue(16'h9000, 0, 0);
        n = 0;
        while (!fault && n < 10) begin @(posedge clk); #1; n++; end
        check("illegal_fault", {31'd0, fault}, 32'd1);
        check_sticky("illegal", 1'b0, 1'b1);

        do_reset();
        @(posedge clk); #3;
        check("mid_fetch_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        txn_no++;
        $display("txn %0d: reset asserted mid-FETCH", txn_no);
        check("mid_fetch_reset_req", {31'd0, mem_req}, 32'd0);
        check("mid_fetch_reset_out", {31'd0, out_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_final", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters SHALL be:
- MEM_TIMEOUT, default 15: cycles mem_req may stay high without mem_ack before fault.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- mem_rdata  in  16  instruction/load data.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read; valid only with mem_req.
- src_sel  out  3  register-file source select.
- dst_sel  out  3  register-file destination select.
- in_en  out  1  register-file write strobe.
- out_en  out  1  register-file drives src register onto the bus.
- pc_inc  out  1  register-file increments r0 (PC).
- bus_sel  out  2  write-data source: 0 mem_rdata, 1 imm, 2 ALU, 3 src bus.
- alu_op  out  1  0 add, 1 sub.
- imm  out  16  zero-extended IR[5:0].
- halted  out  1  HALT executed.
- fault  out  1  illegal opcode or memory timeout.
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on port rst.

Function
REQ-004 IR fields SHALL be: opcode IR[15:12], dst IR[11:9], src IR[8:6], imm IR[5:0].
REQ-005 Opcodes SHALL be: 0 NOP, 1 MOV, 2 LDI, 3 LD, 4 ST, 5 ADD, 6 SUB, 7 JMP, F HALT; all others are illegal.
REQ-006 States SHALL be FETCH, DECODE, EXEC, MEM, HALT, FAULT.
REQ-007 FETCH SHALL drive src_sel=0, out_en=1, mem_req=1 and mem_we=0. On mem_ack it SHALL load IR from mem_rdata, pulse pc_inc for exactly that cycle, and go to DECODE.
REQ-008 DECODE SHALL drive src_sel=IR.src and dst_sel=IR.dst for one cycle, covering register-file read latency, then go to EXEC.
REQ-009 EXEC SHALL act per opcode:
- NOP: go to FETCH.
- MOV: in_en=1, bus_sel=3.
- LDI: in_en=1, bus_sel=1.
- ADD/SUB: in_en=1, bus_sel=2, alu_op=0 for ADD and 1 for SUB.
- JMP: dst_sel=0, in_en=1, bus_sel=3.
- In all write cases above: one cycle, then go to FETCH.
- LD/ST: go to MEM.
- HALT: go to HALT.
- Illegal opcode: go to FAULT.
REQ-010 MEM for LD SHALL drive src_sel=IR.src, out_en=1 (address) and mem_req=1 with mem_we=0. On mem_ack in the same cycle it SHALL drive in_en=1, bus_sel=0 and dst_sel=IR.dst, then go to FETCH.
REQ-011 MEM for ST SHALL drive src_sel=IR.src, out_en=1 (data), dst_sel=IR.dst (address) and mem_req=1 with mem_we=1. On mem_ack it SHALL go to FETCH.
REQ-012 A timeout counter SHALL clear on entry to FETCH/MEM and count each cycle with mem_req=1 and mem_ack=0. When it reaches MEM_TIMEOUT, the block SHALL go to FAULT and drop mem_req on the next cycle.
REQ-013 mem_ack SHALL be ignored while mem_req=0.
REQ-014 pc_inc and an in_en with dst_sel=0 SHALL never assert in the same cycle.
REQ-015 HALT and FAULT SHALL be sticky until reset; all strobes SHALL be 0 in those states; halted or fault respectively SHALL be 1.
REQ-016 All strobe outputs SHALL be registered-state decodes and glitch-free, with no combinational path from mem_rdata.

Reset
REQ-017 While rst=0, the block SHALL hold the following, independent of clk:
- state=FETCH, IR=0, timeout counter=0.
- mem_req, mem_we, in_en, out_en, pc_inc=0.
- src_sel, dst_sel, bus_sel, alu_op=0; halted, fault=0.
REQ-018 Reset asserted mid-transaction SHALL drop mem_req immediately.
REQ-019 After reset release, mem_req SHALL assert on the first clock edge.

Structure
REQ-020 A shared package SHALL hold: opcode constants, state enum, bus_sel encodings, alu_op encodings, IR field positions.
REQ-021 A single sub-module, seq_timeout, SHALL implement the MEM_TIMEOUT counter; everything else SHALL live in control_sequencer.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- IR=0x2205 (LDI r1,5), ack after 2 wait cycles -> pc_inc exactly 1 cycle; EXEC in_en=1, dst_sel=1, bus_sel=1, imm=0x0005.
- IR=0x5450 (ADD r2,r1) -> EXEC in_en=1, dst_sel=2, src_sel=1, bus_sel=2, alu_op=0; next cycle mem_req=1.
- IR=0x3440 (LD r2,[r1]), ack after 3 cycles -> ack cycle in_en=1, bus_sel=0, dst_sel=2, mem_we=0.
- IR=0x4440 (ST [r2],r1) -> mem_we=1, out_en=1, src_sel=1, dst_sel=2 until ack.
- IR=0x7040 (JMP r1) -> in_en=1, dst_sel=0, pc_inc=0 that cycle.
- No ack for MEM_TIMEOUT cycles, then IR=0x9000, then IR=0xF000, each after reset -> fault=1, mem_req=0; fault=1; halted=1. rst low mid-FETCH -> mem_req=0 the same cycle.
